// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding, parity mode codes and default frame
// constants; the transmitter successor reuses the same package.
package uart_pkg;

    localparam int NB_STATE     = 3;
    localparam int DEF_SB_TICK  = 16;
    localparam int DEF_NB_DATA  = 8;
    localparam int DEF_DVSR_BIT = 8;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Mode 2'b11 is deliberately treated like PAR_NONE.
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator shared by the UART receiver and transmitter.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   i_dvsr     : runtime divisor, one tick every i_dvsr+1 clk cycles
//   tick       : single-cycle oversampling tick
module uart_baud_gen #(
    parameter int DVSR_BIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] i_dvsr,
    output logic                tick
);

    logic [DVSR_BIT-1:0] cnt_reg;

    // ">=" rather than "==" so that lowering i_dvsr below the current count
    // wraps immediately instead of running the counter all the way round.
    assign tick = (cnt_reg >= i_dvsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_gen.sv
// Parametrised, runtime-configurable UART receiver.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   i_dvsr        : baud divisor (tick every i_dvsr+1 clk)
//   i_parity_mode : 00 none, 01 even, 10 odd, 11 none
//   i_two_stop    : 0 one stop bit, 1 two stop bits
//   rx            : asynchronous serial input, idle high
//   rd_uart       : consumer acknowledge of rx_data
//   rx_data       : received word (LSB first on the line)
//   rx_valid      : rx_data holds an unread word
//   parity_err    : parity mismatch for the word in rx_data
//   frame_err     : a stop bit of that word was sampled low
//   overrun_err   : one-cycle pulse when a completed frame is dropped
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int NB_DATA  = DEF_NB_DATA,
    parameter int SB_TICK  = DEF_SB_TICK,
    parameter int DVSR_BIT = DEF_DVSR_BIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] i_dvsr,
    input  logic [1:0]          i_parity_mode,
    input  logic                i_two_stop,
    input  logic                rx,
    input  logic                rd_uart,
    output logic [NB_DATA-1:0]  rx_data,
    output logic                rx_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun_err
);

    localparam int S_W = $clog2(SB_TICK);
    localparam int N_W = $clog2(NB_DATA + 1);
    localparam logic [S_W-1:0] S_MID  = S_W'(SB_TICK / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

    // Odd mode expects an odd total count of ones over data + parity bit.
    function automatic logic parity_error(input logic [NB_DATA-1:0] d,
                                          input logic               pbit,
                                          input logic [1:0]         mode);
        return (^d ^ pbit) != (mode == PAR_ODD);
    endfunction

    logic tick;

    uart_baud_gen #(
        .DVSR_BIT(DVSR_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .i_dvsr(i_dvsr),
        .tick  (tick)
    );

    // Two-flop synchroniser; flops reset to the idle line level.
    logic rx_p0;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    rx_state_t          state_reg,    state_next;
    logic [S_W-1:0]     s_reg,        s_next;
    logic [N_W-1:0]     n_reg,        n_next;
    logic [NB_DATA-1:0] b_reg,        b_next;
    logic [1:0]         mode_reg,     mode_next;
    logic               two_stop_reg, two_stop_next;
    logic               perr_reg,     perr_next;
    logic               ferr_reg,     ferr_next;
    logic               frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            mode_reg     <= PAR_NONE;
            two_stop_reg <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            mode_reg     <= mode_next;
            two_stop_reg <= two_stop_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        s_next        = s_reg;
        n_next        = n_reg;
        b_next        = b_reg;
        mode_next     = mode_reg;
        two_stop_next = two_stop_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        frame_done    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // Start edge is taken without waiting for a tick; the frame
                // configuration is frozen here for the whole frame.
                if (!rx_s) begin
                    state_next    = ST_START;
                    s_next        = '0;
                    mode_next     = i_parity_mode;
                    two_stop_next = i_two_stop;
                    perr_next     = 1'b0;
                    ferr_next     = 1'b0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (s_reg == S_MID) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[NB_DATA-1:1]};
                        if (n_reg == N_LAST) begin
                            n_next     = '0;
                            state_next = par_enabled(mode_reg) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    if (s_reg == S_LAST) begin
                        perr_next  = parity_error(b_reg, rx_s, mode_reg);
                        state_next = ST_STOP;
                        s_next     = '0;
                        n_next     = '0;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                // n counts stop bits already sampled.
                if (tick) begin
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        if (!rx_s) begin
                            ferr_next = 1'b1;
                        end
                        if (n_reg == N_W'(two_stop_reg)) begin
                            state_next = ST_IDLE;
                            frame_done = 1'b1;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Delivery. ferr_next is used so the flag includes the final stop bit
    // sampled in the completion cycle itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rd_uart) begin
                    rx_data    <= b_reg;
                    parity_err <= perr_reg;
                    frame_err  <= ferr_next;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rd_uart && rx_valid) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_gen.sv
module tb_uart_rx_gen;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i_dvsr;
    logic [1:0] i_parity_mode;
    logic       i_two_stop;
    logic       rx;
    logic       rd_uart;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;

    int checks   = 0;
    int failures = 0;
    int ovr_cycles;
    bit valid_seen;

    uart_rx_gen #(
        .NB_DATA (8),
        .SB_TICK (16),
        .DVSR_BIT(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_dvsr       (i_dvsr),
        .i_parity_mode(i_parity_mode),
        .i_two_stop   (i_two_stop),
        .rx           (rx),
        .rd_uart      (rd_uart),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold the line at v for len clocks (dvsr=1: 32 clk per bit). When
    // rd_on_done is set, rd_uart is raised exactly in a frame completion cycle.
    task automatic hold(input logic v, input int len, input bit rd_on_done);
        rx = v;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            ovr_cycles += int'(overrun_err);
            if (rx_valid) valid_seen = 1'b1;
            rd_uart = rd_on_done && dut.frame_done;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                              input bit two_stop, input bit rd_on_done);
        hold(1'b0, 32, rd_on_done);
        for (int i = 0; i < 8; i++) hold(d[i], 32, rd_on_done);
        if (par_en) hold(par_bit, 32, rd_on_done);
        hold(1'b1, 32, rd_on_done);
        if (two_stop) hold(1'b1, 32, rd_on_done);
        hold(1'b1, 32, rd_on_done);
    endtask

    task automatic read_word();
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        check("read_clears_valid", 16'(rx_valid), 16'd0);
    endtask

    initial begin
        reset         = 1'b1;
        i_dvsr        = 8'd1;
        i_parity_mode = PAR_NONE;
        i_two_stop    = 1'b0;
        rx            = 1'b1;
        rd_uart       = 1'b0;
        ovr_cycles    = 0;
        valid_seen    = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_valid", 16'(rx_valid), 16'd0);
        check("rst_data", 16'(rx_data), 16'h00);
        check("rst_perr", 16'(parity_err), 16'd0);
        check("rst_ferr", 16'(frame_err), 16'd0);
        check("rst_ovr", 16'(overrun_err), 16'd0);
        check("rst_state", 16'(dut.state_reg), 16'(ST_IDLE));

        // 8N1, 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("a5_data", 16'(rx_data), 16'h00A5);
        check("a5_valid", 16'(rx_valid), 16'd1);
        check("a5_perr", 16'(parity_err), 16'd0);
        check("a5_ferr", 16'(frame_err), 16'd0);
        read_word();

        // Even parity, correct parity bit
        i_parity_mode = PAR_EVEN;
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        check("even_ok_data", 16'(rx_data), 16'h0003);
        check("even_ok_perr", 16'(parity_err), 16'd0);
        read_word();
        // Even parity, wrong parity bit
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        check("even_bad_data", 16'(rx_data), 16'h0003);
        check("even_bad_valid", 16'(rx_valid), 16'd1);
        check("even_bad_perr", 16'(parity_err), 16'd1);
        check("even_bad_ferr", 16'(frame_err), 16'd0);
        read_word();
        // Odd parity, correct parity bit
        i_parity_mode = PAR_ODD;
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        check("odd_ok_data", 16'(rx_data), 16'h0003);
        check("odd_ok_perr", 16'(parity_err), 16'd0);
        read_word();

        // Two stop bits, second one low for the first 20 clk of its slot
        i_parity_mode = PAR_NONE;
        i_two_stop    = 1'b1;
        hold(1'b0, 32, 1'b0);
        for (int i = 0; i < 8; i++) hold(i[0] ? (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0
                                             : (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0, 32, 1'b0);
        hold(1'b1, 32, 1'b0);
        hold(1'b0, 20, 1'b0);
        hold(1'b1, 12, 1'b0);
        hold(1'b1, 64, 1'b0);
        check("stop2_data", 16'(rx_data), 16'h003C);
        check("stop2_valid", 16'(rx_valid), 16'd1);
        check("stop2_ferr", 16'(frame_err), 16'd1);
        check("stop2_perr", 16'(parity_err), 16'd0);
        check("stop2_state", 16'(dut.state_reg), 16'(ST_IDLE));
        read_word();

        // Start-bit glitch of 8 clk
        i_two_stop = 1'b0;
        valid_seen = 1'b0;
        hold(1'b0, 8, 1'b0);
        hold(1'b1, 64, 1'b0);
        check("glitch_valid", 16'(rx_valid), 16'd0);
        check("glitch_seen", 16'(valid_seen), 16'd0);
        check("glitch_state", 16'(dut.state_reg), 16'(ST_IDLE));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_glitch_data", 16'(rx_data), 16'h005A);
        check("post_glitch_valid", 16'(rx_valid), 16'd1);
        check("post_glitch_ferr", 16'(frame_err), 16'd0);
        read_word();

        // Overrun: 0x11 then 0x22 without reading
        ovr_cycles = 0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_data", 16'(rx_data), 16'h0011);
        check("ovr_valid", 16'(rx_valid), 16'd1);
        check("ovr_pulse_cycles", 16'(ovr_cycles), 16'd1);
        // 0x11 still unread; rd_uart in the 0x22 completion cycle
        ovr_cycles = 0;
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rd_done_data", 16'(rx_data), 16'h0022);
        check("rd_done_valid", 16'(rx_valid), 16'd1);
        check("rd_done_ovr", 16'(ovr_cycles), 16'd0);
        read_word();

        // Reset in the middle of the data bits of 0xFF
        valid_seen = 1'b0;
        hold(1'b0, 32, 1'b0);
        for (int i = 0; i < 3; i++) hold(1'b1, 32, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold(1'b1, 64, 1'b0);
        check("midrst_valid", 16'(rx_valid), 16'd0);
        check("midrst_state", 16'(dut.state_reg), 16'(ST_IDLE));
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_seen", 16'(valid_seen), 16'd1);
        check("after_rst_data", 16'(rx_data), 16'h0081);
        check("after_rst_valid", 16'(rx_valid), 16'd1);
        check("after_rst_perr", 16'(parity_err), 16'd0);
        check("after_rst_ferr", 16'(frame_err), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
